rps_round_ctrl: RTL and testbench
=================================

// Module: rps_round_ctrl
// PURPOSE
//  Upstream feeder for the RPS arbitrator. Accepts one move per player over valid/ready,
//  holds both, then presents them as one-hot r/p/s with a single-cycle go1/go2 strobe.
//  Waits for the arbitrator's dut_busy acknowledge, then reopens for the next round.
//  Also handles player timeout (forfeit), bad move codes and round counting.
// PARAMETERS
//  TIMEOUT   16  max cycles a latched move waits for the other player before forfeit (>=1)
//  ACK_WAIT  4   max cycles in ACK for dut_busy to rise before ack_err (>=1)
//  RW        16  width of round_cnt
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   asynchronous, active-low reset
//  mv1        in   2   player1 move: 01 rock, 10 paper, 11 scissors, 00 illegal
//  mv1_valid  in   1   player1 move valid
//  mv1_ready  out  1   player1 slot empty (move accepted when valid&ready)
//  mv2/mv2_valid/mv2_ready   same for player2
//  r1,p1,s1   out  1   player1 one-hot move to arbitrator
//  r2,p2,s2   out  1   player2 one-hot move to arbitrator
//  go1,go2    out  1   round strobe to arbitrator (always asserted together)
//  dut_busy   in   1   arbitrator acknowledge
//  round_cnt  out  RW  rounds issued, wraps
//  forfeit1/2 out  1   one-cycle pulse: that player timed out
//  bad_move1/2 out 1   one-cycle pulse: illegal code 00 was offered
//  ack_err    out  1   one-cycle pulse: dut_busy never rose within ACK_WAIT
// BEHAVIOUR
//  Reset (async, rst=0): state COLLECT, both slots empty, all outputs 0, counters 0.
//  Slots: slotN loads on mvN_valid & mvN_ready & mvN!=00; mvN_ready = slotN empty & state==COLLECT.
//   mvN=00 with valid&ready: not loaded, bad_moveN pulses next cycle, ready stays 1.
//  States:
//   COLLECT: both slots full -> FIRE next cycle. Exactly one full -> wait counter counts each
//    cycle; reaching TIMEOUT -> forfeit of the EMPTY player pulses, full slot cleared, counter 0.
//    Counter cleared whenever zero or two slots are full. Both moves arriving same cycle -> FIRE.
//    If the second move arrives in the cycle the counter hits TIMEOUT, the move wins (no forfeit).
//   FIRE (exactly 1 cycle): go1=go2=1, r/p/s one-hot from slots; round_cnt+1 (mod 2^RW)
//    on exit; -> ACK.
//   ACK: go low, r/p/s held stable. dut_busy=1 -> clear slots, -> COLLECT.
//    ACK_WAIT cycles without dut_busy -> ack_err pulse, clear slots, -> COLLECT (round dropped,
//    round_cnt not rolled back).
//  Outside FIRE/ACK, r/p/s outputs are 0. go1/go2 never high two consecutive cycles.
//  Reset mid-round (any state): immediate return to reset values, no pulses emitted.
//  All pulse outputs registered, high exactly one cycle.
// TESTING
//  1. mv1=01,mv2=11 both valid same cycle -> FIRE next cycle: r1=1,s2=1,go1=go2=1 one cycle;
//     busy=1 next cycle -> COLLECT, round_cnt=1, both readies 1.
//  2. mv1=10 only, TIMEOUT=16 -> forfeit2 pulse 16 cycles after load, mv1_ready returns 1, no go.
//  3. mv2=00 valid -> bad_move2 pulse, mv2_ready stays 1, no state change; then mv2=10 loads.
//  4. dut_busy held 0 after FIRE, ACK_WAIT=4 -> ack_err pulse on 4th ACK cycle, COLLECT, round_cnt=1.
//  5. RW=2, 4 complete rounds -> round_cnt 1,2,3,0.
//  6. rst low during ACK -> outputs 0 asynchronously, slots empty, round_cnt=0 after release.

Source files
------------

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl
//   Round feeder for the rock/paper/scissors arbitrator. Each player hands in one
//   move over a valid/ready slot. Once both slots hold a legal move the block
//   drives the moves as one-hot r/p/s with a single-cycle go strobe. It then waits
//   for the arbitrator's dut_busy acknowledge before reopening the slots.
//   Player timeouts (forfeit), illegal codes and lost acknowledges are reported
//   as one-cycle pulses. A wrapping counter tracks the rounds issued.
//
// Parameters
//   TIMEOUT   cycles a lone latched move waits for the other player (>=1)
//   ACK_WAIT  cycles spent in ACK waiting for dut_busy (>=1)
//   RW        width of round_cnt
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   mv1/mv1_valid/mv1_ready   player1 move: 01 rock, 10 paper, 11 scissors, 00 illegal
//   mv2/mv2_valid/mv2_ready   player2 move, same encoding
//   r1,p1,s1 / r2,p2,s2       one-hot moves to the arbitrator (FIRE and ACK only)
//   go1, go2                  single-cycle round strobe, always high together
//   dut_busy                  arbitrator acknowledge
//   round_cnt                 rounds issued, wraps
//   forfeit1/2                pulse: that player timed out
//   bad_move1/2               pulse: illegal code 00 was offered
//   ack_err                   pulse: dut_busy did not rise within ACK_WAIT cycles
module rps_round_ctrl #(
  parameter int TIMEOUT  = 16,
  parameter int ACK_WAIT = 4,
  parameter int RW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mv1,
  input  logic          mv1_valid,
  output logic          mv1_ready,
  input  logic [1:0]    mv2,
  input  logic          mv2_valid,
  output logic          mv2_ready,
  output logic          r1,
  output logic          p1,
  output logic          s1,
  output logic          r2,
  output logic          p2,
  output logic          s2,
  output logic          go1,
  output logic          go2,
  input  logic          dut_busy,
  output logic [RW-1:0] round_cnt,
  output logic          forfeit1,
  output logic          forfeit2,
  output logic          bad_move1,
  output logic          bad_move2,
  output logic          ack_err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(ACK_WAIT + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FIRE    = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t        state_r;
  logic [1:0]    slot1_r;
  logic [1:0]    slot2_r;
  logic [WW-1:0] wait_cnt_r;
  logic [AW-1:0] ack_cnt_r;

  logic          acc1_s, acc2_s;
  logic          load1_s, load2_s;
  logic          bad1_s, bad2_s;
  logic          full1_s, full2_s;
  logic          nfull1_s, nfull2_s;
  logic [1:0]    nslot1_s, nslot2_s;

  // Move code to {r,p,s}; the illegal code never reaches a slot but decodes to 0.
  function automatic logic [2:0] to_rps(input logic [1:0] mv);
    logic [2:0] res;
    case (mv)
      2'b01:   res = 3'b100;
      2'b10:   res = 3'b010;
      2'b11:   res = 3'b001;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // A slot is empty exactly when it holds 00, because 00 is never loaded.
  assign mv1_ready = (slot1_r == 2'b00) && (state_r == COLLECT);
  assign mv2_ready = (slot2_r == 2'b00) && (state_r == COLLECT);

  // Handshake decode and the slot contents as they will be after this edge.
  always_comb begin
    acc1_s   = mv1_valid & mv1_ready;
    acc2_s   = mv2_valid & mv2_ready;
    load1_s  = acc1_s & (mv1 != 2'b00);
    load2_s  = acc2_s & (mv2 != 2'b00);
    bad1_s   = acc1_s & (mv1 == 2'b00);
    bad2_s   = acc2_s & (mv2 == 2'b00);
    full1_s  = (slot1_r != 2'b00);
    full2_s  = (slot2_r != 2'b00);
    nfull1_s = full1_s | load1_s;
    nfull2_s = full2_s | load2_s;
    if (load1_s) begin
      nslot1_s = mv1;
    end else begin
      nslot1_s = slot1_r;
    end
    if (load2_s) begin
      nslot2_s = mv2;
    end else begin
      nslot2_s = slot2_r;
    end
  end

  // Round FSM with slots, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= COLLECT;
      slot1_r    <= 2'b00;
      slot2_r    <= 2'b00;
      wait_cnt_r <= '0;
      ack_cnt_r  <= '0;
      round_cnt  <= '0;
      {r1, p1, s1} <= 3'b000;
      {r2, p2, s2} <= 3'b000;
      go1        <= 1'b0;
      go2        <= 1'b0;
      forfeit1   <= 1'b0;
      forfeit2   <= 1'b0;
      bad_move1  <= 1'b0;
      bad_move2  <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      forfeit1  <= 1'b0;
      forfeit2  <= 1'b0;
      ack_err   <= 1'b0;
      // Ready is only high in COLLECT, so illegal offers can only arrive there.
      bad_move1 <= bad1_s;
      bad_move2 <= bad2_s;
      case (state_r)
        COLLECT: begin
          slot1_r <= nslot1_s;
          slot2_r <= nslot2_s;
          if (nfull1_s && nfull2_s) begin
            // A completing arrival wins even on the timeout cycle.
            state_r      <= FIRE;
            wait_cnt_r   <= '0;
            go1          <= 1'b1;
            go2          <= 1'b1;
            {r1, p1, s1} <= to_rps(nslot1_s);
            {r2, p2, s2} <= to_rps(nslot2_s);
          end else if (full1_s ^ full2_s) begin
            if (wait_cnt_r == WW'(TIMEOUT - 1)) begin
              // The player with the empty slot forfeits; drop the lone move.
              forfeit1   <= ~full1_s;
              forfeit2   <= ~full2_s;
              slot1_r    <= 2'b00;
              slot2_r    <= 2'b00;
              wait_cnt_r <= '0;
            end else begin
              wait_cnt_r <= wait_cnt_r + WW'(1);
            end
          end else begin
            // No slot was full before this edge: the wait starts from zero.
            wait_cnt_r <= '0;
          end
        end
        FIRE: begin
          go1       <= 1'b0;
          go2       <= 1'b0;
          round_cnt <= round_cnt + RW'(1);
          ack_cnt_r <= '0;
          state_r   <= ACK;
        end
        ACK: begin
          if (dut_busy || (ack_cnt_r == AW'(ACK_WAIT - 1))) begin
            ack_err      <= ~dut_busy;
            slot1_r      <= 2'b00;
            slot2_r      <= 2'b00;
            {r1, p1, s1} <= 3'b000;
            {r2, p2, s2} <= 3'b000;
            ack_cnt_r    <= '0;
            state_r      <= COLLECT;
          end else begin
            ack_cnt_r <= ack_cnt_r + AW'(1);
          end
        end
        default: begin
          state_r      <= COLLECT;
          slot1_r      <= 2'b00;
          slot2_r      <= 2'b00;
          wait_cnt_r   <= '0;
          ack_cnt_r    <= '0;
          go1          <= 1'b0;
          go2          <= 1'b0;
          {r1, p1, s1} <= 3'b000;
          {r2, p2, s2} <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb_rps_round_ctrl
//   Directed bench for rps_round_ctrl (TIMEOUT=16, ACK_WAIT=4, RW=2).
//   Stimulus pushes the expected output event (go strobe, forfeit, bad move,
//   ack_err) into a queue. A negedge monitor pops and compares whenever the DUT
//   raises any of those outputs. Cycle-exact timing and level outputs are
//   checked directly by the stimulus thread.
module tb_rps_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mv1, mv2;
  logic       mv1_valid, mv2_valid;
  logic       mv1_ready, mv2_ready;
  logic       r1, p1, s1, r2, p2, s2;
  logic       go1, go2;
  logic       dut_busy;
  logic [1:0] round_cnt;
  logic       forfeit1, forfeit2, bad_move1, bad_move2, ack_err;

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_cnt;
  logic [14:0] exp_q[$];

  rps_round_ctrl #(.TIMEOUT(16), .ACK_WAIT(4), .RW(2)) dut (
    .clk(clk), .rst(rst),
    .mv1(mv1), .mv1_valid(mv1_valid), .mv1_ready(mv1_ready),
    .mv2(mv2), .mv2_valid(mv2_valid), .mv2_ready(mv2_ready),
    .r1(r1), .p1(p1), .s1(s1), .r2(r2), .p2(p2), .s2(s2),
    .go1(go1), .go2(go2), .dut_busy(dut_busy), .round_cnt(round_cnt),
    .forfeit1(forfeit1), .forfeit2(forfeit2),
    .bad_move1(bad_move1), .bad_move2(bad_move2), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Event record: {go1,go2, r1p1s1, r2p2s2, f1,f2,b1,b2,ack_err, round_cnt}
  function automatic logic [14:0] ev(input logic g, input logic [2:0] a, input logic [2:0] b,
                                     input logic [4:0] fl, input logic [1:0] c);
    return {g, g, a, b, fl, c};
  endfunction

  // Monitor: every output event is compared against the queue head.
  always @(negedge clk) begin
    if (rst && (go1 | go2 | forfeit1 | forfeit2 | bad_move1 | bad_move2 | ack_err)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL event_unexpected: got %0h, expected none",
                 {go1, go2, r1, p1, s1, r2, p2, s2, forfeit1, forfeit2,
                  bad_move1, bad_move2, ack_err, round_cnt});
      end else begin
        chk("event", {17'd0, go1, go2, r1, p1, s1, r2, p2, s2, forfeit1, forfeit2,
                      bad_move1, bad_move2, ack_err, round_cnt},
            {17'd0, exp_q.pop_front()});
      end
    end
  end

  // Present both moves in one cycle; returns in the FIRE cycle.
  task automatic issue(input logic [1:0] a, input logic [1:0] b,
                       input logic [2:0] ea, input logic [2:0] eb);
    @(posedge clk); #1;
    mv1 = a; mv2 = b; mv1_valid = 1'b1; mv2_valid = 1'b1;
    exp_q.push_back(ev(1'b1, ea, eb, 5'b00000, exp_cnt));
    @(posedge clk); #1;
    mv1_valid = 1'b0; mv2_valid = 1'b0;
    chk("fire_ready_low", {mv1_ready, mv2_ready}, 32'd0);
  endtask

  // Called in the FIRE cycle; finishes the round via dut_busy or via ack_err.
  task automatic ack_round(input logic with_busy, input logic [2:0] ea, input logic [2:0] eb);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 2'd1;
    chk("ack_go_low", {go1, go2}, 32'd0);
    chk("ack_rps_held", {r1, p1, s1, r2, p2, s2}, {ea, eb});
    chk("ack_round_cnt", round_cnt, exp_cnt);
    if (with_busy) begin
      dut_busy = 1'b1;
      @(posedge clk); #1;
      dut_busy = 1'b0;
    end else begin
      exp_q.push_back(ev(1'b0, 3'b000, 3'b000, 5'b00001, exp_cnt));
      repeat (3) @(posedge clk);
      #1;
      chk("ack_err_early", ack_err, 32'd0);
      @(posedge clk); #1;
      chk("ack_err_pulse", ack_err, 32'd1);
    end
    chk("post_round_ready", {mv1_ready, mv2_ready}, 32'd3);
    chk("post_round_rps", {r1, p1, s1, r2, p2, s2}, 32'd0);
    chk("post_round_cnt", round_cnt, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mv1 = 2'b00; mv2 = 2'b00; mv1_valid = 1'b0; mv2_valid = 1'b0;
    dut_busy = 1'b0; exp_cnt = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {r1, p1, s1, r2, p2, s2, go1, go2, forfeit1, forfeit2,
                          bad_move1, bad_move2, ack_err, round_cnt}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", {mv1_ready, mv2_ready}, 32'd3);

    // 1: rock vs scissors in one cycle, acknowledged -> round_cnt 1
    issue(2'b01, 2'b11, 3'b100, 3'b001);
    ack_round(1'b1, 3'b100, 3'b001);

    // 2: paper alone -> forfeit2 sixteen cycles after the load
    @(posedge clk); #1;
    mv1 = 2'b10; mv1_valid = 1'b1;
    exp_q.push_back(ev(1'b0, 3'b000, 3'b000, 5'b01000, exp_cnt));
    @(posedge clk); #1;
    mv1_valid = 1'b0;
    chk("lone_ready1", mv1_ready, 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("forfeit_early", forfeit2, 32'd0);
    @(posedge clk); #1;
    chk("forfeit_pulse", {forfeit1, forfeit2, go1}, 32'd2);
    chk("forfeit_ready1", mv1_ready, 32'd1);

    // 3: illegal code from player2, then paper; player1 rock completes -> round_cnt 2
    @(posedge clk); #1;
    mv2 = 2'b00; mv2_valid = 1'b1;
    exp_q.push_back(ev(1'b0, 3'b000, 3'b000, 5'b00010, exp_cnt));
    @(posedge clk); #1;
    mv2_valid = 1'b0;
    chk("bad_pulse", bad_move2, 32'd1);
    chk("bad_ready2", mv2_ready, 32'd1);
    mv2 = 2'b10; mv2_valid = 1'b1;
    @(posedge clk); #1;
    mv2_valid = 1'b0;
    chk("load2_ready", {mv1_ready, mv2_ready}, 32'd2);
    mv1 = 2'b01; mv1_valid = 1'b1;
    exp_q.push_back(ev(1'b1, 3'b100, 3'b010, 5'b00000, exp_cnt));
    @(posedge clk); #1;
    mv1_valid = 1'b0;
    ack_round(1'b1, 3'b100, 3'b010);

    // Boundary: second move arrives on the timeout cycle -> round fires, no forfeit
    @(posedge clk); #1;
    mv2 = 2'b11; mv2_valid = 1'b1;
    @(posedge clk); #1;
    mv2_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    mv1 = 2'b10; mv1_valid = 1'b1;
    exp_q.push_back(ev(1'b1, 3'b010, 3'b001, 5'b00000, exp_cnt));
    @(posedge clk); #1;
    mv1_valid = 1'b0;
    chk("late_move_wins", {go1, forfeit1, forfeit2}, 32'd4);
    ack_round(1'b1, 3'b010, 3'b001);

    // 4: no acknowledge -> ack_err, round_cnt wraps to 0 (RW=2)
    issue(2'b11, 2'b10, 3'b001, 3'b010);
    ack_round(1'b0, 3'b001, 3'b010);

    // 5: one more round after the wrap -> round_cnt 1
    issue(2'b01, 2'b01, 3'b100, 3'b100);
    ack_round(1'b1, 3'b100, 3'b100);

    // 6: reset during ACK clears everything asynchronously
    issue(2'b01, 2'b10, 3'b100, 3'b010);
    @(posedge clk); #1;
    chk("pre_reset_rps", {r1, p1, s1, r2, p2, s2}, 32'b100010);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", {r1, p1, s1, r2, p2, s2, go1, go2, round_cnt}, 32'd0);
    exp_cnt = 2'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_ready", {mv1_ready, mv2_ready}, 32'd3);
    chk("after_reset_cnt", round_cnt, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
